// File: rtl/cmd_collector.sv
// Collects a 3-byte (command, address, data) frame from a UART RX byte stream and
// presents it with a one-cycle cmd_ready strobe; stale partial frames are dropped on timeout.
module cmd_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] cmd,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       cmd_ready,
  output logic       busy,
  output logic       frame_timeout
);

  typedef enum logic [1:0] {StCmd, StAddr, StData} state_e;

  localparam bit             TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_buf_q, cmd_buf_d;
  logic [7:0]       addr_buf_q, addr_buf_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             frame_timeout_q, frame_timeout_d;
  logic             timeout_hit;

  // Fires on the edge that would bring the idle count up to TIMEOUT_CYCLES.
  assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cmd_buf_d       = cmd_buf_q;
    addr_buf_d      = addr_buf_q;
    cmd_d           = cmd_q;
    addr_d          = addr_q;
    data_d          = data_q;
    cmd_ready_d     = 1'b0;
    frame_timeout_d = 1'b0;

    unique case (state_q)
      StCmd: begin
        cnt_d = '0;
        if (rx_valid) begin
          cmd_buf_d = rx_data;
          state_d   = StAddr;
        end
      end
      StAddr, StData: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == StAddr) begin
            addr_buf_d = rx_data;
            state_d    = StData;
          end else begin
            cmd_d       = cmd_buf_q;
            addr_d      = addr_buf_q;
            data_d      = rx_data;
            cmd_ready_d = 1'b1;
            state_d     = StCmd;
          end
        end else if (timeout_hit) begin
          cnt_d           = '0;
          cmd_buf_d       = '0;
          addr_buf_d      = '0;
          frame_timeout_d = 1'b1;
          state_d         = StCmd;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StCmd;
      end
    endcase

    busy_d = (state_d != StCmd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StCmd;
      cnt_q           <= '0;
      cmd_buf_q       <= '0;
      addr_buf_q      <= '0;
      cmd_q           <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      cmd_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
      frame_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cmd_buf_q       <= cmd_buf_d;
      addr_buf_q      <= addr_buf_d;
      cmd_q           <= cmd_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      cmd_ready_q     <= cmd_ready_d;
      busy_q          <= busy_d;
      frame_timeout_q <= frame_timeout_d;
    end
  end

  assign cmd           = cmd_q;
  assign addr          = addr_q;
  assign data          = data_q;
  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign frame_timeout = frame_timeout_q;

endmodule

// File: tb/tb_cmd_collector.sv
// Directed bench for cmd_collector with a short timeout (10 cycles).
module tb_cmd_collector;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] cmd;
  logic [7:0] addr;
  logic [7:0] data;
  logic       cmd_ready;
  logic       busy;
  logic       frame_timeout;

  int total;
  int bad;

  cmd_collector #(
    .TIMEOUT_CYCLES(10),
    .CNT_W         (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .cmd          (cmd),
    .addr         (addr),
    .data         (data),
    .cmd_ready    (cmd_ready),
    .busy         (busy),
    .frame_timeout(frame_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; inputs and samples sit 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_out(input string name, input logic [7:0] ec, input logic [7:0] ea,
                         input logic [7:0] ed, input logic er, input logic eb, input logic et);
    total++;
    if ({cmd, addr, data, cmd_ready, busy, frame_timeout} !== {ec, ea, ed, er, eb, et}) begin
      bad++;
      $display("FAIL %s: got cmd=%h addr=%h data=%h rdy=%b busy=%b to=%b, want %h %h %h %b %b %b",
               name, cmd, addr, data, cmd_ready, busy, frame_timeout, ec, ea, ed, er, eb, et);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    chk_out("reset_held", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(2);
    chk_out("reset_released", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic_gaps();
    send(8'h57);
    chk_out("basic_b0_busy", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(3);
    send(8'h03);
    idle(4);
    chk_out("basic_b1_hold", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    send(8'hAA);
    chk_out("basic_frame", 8'h57, 8'h03, 8'hAA, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("basic_pulse_end", 8'h57, 8'h03, 8'hAA, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk_out("basic_stable", 8'h57, 8'h03, 8'hAA, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    rx_valid = 1'b1;
    rx_data = 8'h52; tick();
    rx_data = 8'h10; tick();
    chk_out("b2b_partial", 8'h57, 8'h03, 8'hAA, 1'b0, 1'b1, 1'b0);
    rx_data = 8'h00; tick();
    chk_out("b2b_frame1", 8'h52, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
    rx_data = 8'h57; tick();
    chk_out("b2b_f2_b0", 8'h52, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
    rx_data = 8'h11; tick();
    rx_data = 8'hFF; tick();
    rx_valid = 1'b0;
    chk_out("b2b_frame2", 8'h57, 8'h11, 8'hFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("b2b_pulse_end", 8'h57, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    send(8'h57);
    idle(9);
    chk_out("to_before", 8'h57, 8'h11, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("to_fire", 8'h57, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("to_pulse_end", 8'h57, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0);
    send(8'h57); send(8'h05); send(8'h5A);
    chk_out("to_recover", 8'h57, 8'h05, 8'h5A, 1'b1, 1'b0, 1'b0);
    // A byte on the would-be timeout cycle wins.
    send(8'h57);
    idle(9);
    send(8'h22);
    chk_out("to_priority", 8'h57, 8'h05, 8'h5A, 1'b0, 1'b1, 1'b0);
    send(8'h44);
    chk_out("to_priority_frame", 8'h57, 8'h22, 8'h44, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_frame();
    send(8'h57); send(8'h03);
    rst = 1'b0;
    #2;
    chk_out("rst_mid_async", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk_out("rst_mid_idle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h57); send(8'h07);
    chk_out("rst_mid_partial", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    send(8'h33);
    chk_out("rst_mid_frame", 8'h57, 8'h07, 8'h33, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("rst_mid_end", 8'h57, 8'h07, 8'h33, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_no_strobe();
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'(8'hC3 + i * 17);
      tick();
    end
    chk_out("nostrobe_idle", 8'h57, 8'h07, 8'h33, 1'b0, 1'b0, 1'b0);
    send(8'h01);
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'(8'h3C + i * 29);
      tick();
    end
    chk_out("nostrobe_mid", 8'h57, 8'h07, 8'h33, 1'b0, 1'b1, 1'b0);
    send(8'h02); send(8'h03);
    chk_out("nostrobe_frame", 8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_gaps();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    test_no_strobe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
